ring_client_arbiter: RTL and testbench
======================================

// Module: ring_client_arbiter
// PURPOSE
//  Shares the client side of one ring node among N local requesters.
//  TX side: round-robin arbiter. It stamps the requester index into a tag field of
//  each word and presents one word at a time to the node.
//  RX side: steers each word received from the node back to the requester named by
//  its tag field. Words with an illegal tag are dropped and counted.
//  Sits between the ring node client interface and several on-chip clients
//  (SPI bridge, status unit, ...).
// PARAMETERS
//  WIDTH    16  client word width
//  N        4   number of requesters (2..2**TAGBITS)
//  TAGBITS  2   width of the tag field
//  TAGLSB   8   LSB position of the tag field in the word
// PORTS
//  clk          in   1        clock; all state updates on the rising edge
//  rst          in   1        asynchronous reset, active-high
//  req_valid    in   N        requester i has a word to send; held until granted
//  req_data     in   N*WIDTH  word of requester i, at bits [i*WIDTH +: WIDTH]
//  req_grant    out  N        one-hot; word of requester i is captured at this edge
//  node_txdata  out  WIDTH    word offered to the ring node
//  node_txvalid out  1        node_txdata is valid
//  node_txready in   1        node accepts node_txdata at this edge
//  node_rxdata  in   WIDTH    word delivered by the ring node
//  node_rxvalid in   1        node_rxdata is valid
//  node_rxack   out  1        one-cycle pulse: word taken from the node
//  rsp_valid    out  N        one-hot; rsp_data belongs to requester i
//  rsp_data     out  WIDTH    shared response word
//  rsp_ready    in   N        requester i consumes rsp_data at this edge
//  drop_count   out  8        saturating count of words dropped for an illegal tag
// BEHAVIOUR
//  Reset (async, rst=1):
//   - tx state=IDLE, ptr=0, node_txvalid=0, node_txdata=0
//   - rx buffer empty: rsp_valid=0, rsp_data=0; node_rxack=0; drop_count=0
//   - req_grant is forced to 0 while rst=1
//  Any word captured but not yet handed over is discarded on reset.
//  TX FSM (IDLE, HOLD):
//   - IDLE: req_grant is combinational, driven only in IDLE. It selects the first i
//     with req_valid[i]=1, searching ptr, ptr+1, ... mod N.
//     At that edge: node_txdata <= req_data[i], with bits
//     [TAGLSB +: TAGBITS] replaced by i; node_txvalid <= 1; sel <= i; go to HOLD.
//     No req_valid -> stay in IDLE, grant=0.
//   - HOLD: req_grant=0. node_txdata is held stable.
//     On node_txready=1: node_txvalid <= 0, ptr <= (sel+1) mod N, go to IDLE.
//     node_txready=0 -> stay; no timeout.
//   - Throughput is at most one word per 2 cycles.
//     Latency from req_valid to node_txvalid is 1 cycle when idle.
//  RX path (single-entry buffer, independent of TX):
//   - Buffer empty and node_rxvalid=1: node_rxack=1 for exactly that cycle (registered
//     pulse, asserted in the cycle after node_rxvalid is first seen). The word is
//     captured at the same edge that ends the pulse.
//   - node_rxack is never asserted on two consecutive cycles.
//   - Captured word with tag t < N: rsp_data <= word; rsp_valid <= onehot(t).
//     Held until rsp_ready[t]=1. The buffer is free from the next cycle,
//     so back-to-back rx costs at most 3 cycles per word.
//   - Tag t >= N: word is discarded, never shown on rsp_valid; drop_count += 1,
//     saturating at 8'hFF. The buffer stays empty.
//   - rsp_ready bits of non-selected requesters are ignored.
//  Simultaneous events:
//   - TX and RX handshakes in the same cycle proceed independently.
//   - req_valid changing while in HOLD has no effect until the return to IDLE.
//  Tag field arithmetic:
//   - Outgoing tag = i truncated to TAGBITS; requester payload bits in the field are
//     overwritten.
//   - Incoming tag is compared unsigned against N.
// TESTING
//  1. N=4, all req_valid=1, node_txready=1 -> grants 0,1,2,3,0 at 2-cycle spacing;
//     node_txdata[9:8] = 0,1,2,3,0.
//  2. req 1 granted, node_txready=0 for 5 cycles -> node_txvalid=1 with
//     node_txdata stable, no grant; release -> next grant goes to requester 2.
//  3. node_rxdata=16'h0255 (tag 2), node_rxvalid=1 -> single node_rxack pulse,
//     rsp_valid=4'b0100, rsp_data=16'h0255 until rsp_ready[2]=1.
//  4. N=3, rx word with tag 3 -> node_rxack pulse, rsp_valid stays 0,
//     drop_count=1. 300 such words -> drop_count=8'hFF.
//  5. Assert rst during HOLD with rx buffer full -> node_txvalid=0, rsp_valid=0
//     immediately. After release, req 0 and 2 valid -> req 0 granted first.
//  6. TX accept and RX capture on the same edge -> both complete; no lost or
//     duplicated word.

Source files
------------

// File: rtl/ring_client_arbiter.sv
// ring_client_arbiter: round-robin tagged TX toward one ring node, tag-steered RX back to N requesters
module ring_client_arbiter #(
  parameter int WIDTH = 16,
  parameter int N = 4,
  parameter int TAGBITS = 2,
  parameter int TAGLSB = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_grant,
  output logic [WIDTH-1:0]   node_txdata,
  output logic               node_txvalid,
  input  logic               node_txready,
  input  logic [WIDTH-1:0]   node_rxdata,
  input  logic               node_rxvalid,
  output logic               node_rxack,
  output logic [N-1:0]       rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  input  logic [N-1:0]       rsp_ready,
  output logic [7:0]         drop_count
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [TAGBITS-1:0] ptr, sel, gidx, rxtag;
  logic [2*N-1:0] rot;
  logic [WIDTH-1:0] txw;
  logic found;
  // rotating the doubled request vector puts ptr at bit 0, so the search uses constant indices
  always_comb begin
    rot = {req_valid, req_valid} >> ptr;
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < N; k++)
      if (!found && rot[k]) begin
        found = 1'b1;
        gidx = TAGBITS'((int'(ptr) + k) % N);
      end
    txw = '0;
    for (int i = 0; i < N; i++)
      if (int'(gidx) == i) txw = req_data[i*WIDTH +: WIDTH];
    txw[TAGLSB +: TAGBITS] = gidx;
    req_grant = (!rst && state == IDLE && found) ? N'(1) << gidx : '0;
    rxtag = node_rxdata[TAGLSB +: TAGBITS];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      node_txvalid <= 1'b0;
      node_txdata <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        node_txdata <= txw;
        node_txvalid <= 1'b1;
        sel <= gidx;
        state <= HOLD;
      end
    end else if (node_txready) begin
      node_txvalid <= 1'b0;
      ptr <= TAGBITS'((int'(sel) + 1) % N);
      state <= IDLE;
    end
  // the ack pulse itself marks the capture edge, so it can never repeat back to back
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      node_rxack <= 1'b0;
      rsp_valid <= '0;
      rsp_data <= '0;
      drop_count <= '0;
    end else begin
      node_rxack <= !node_rxack && rsp_valid == '0 && node_rxvalid;
      if (node_rxack) begin
        if (int'(rxtag) < N) begin
          rsp_valid <= N'(1) << rxtag;
          rsp_data <= node_rxdata;
        end else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else if ((rsp_valid & rsp_ready) != '0) rsp_valid <= '0;
    end
endmodule

// File: tb/tb_ring_client_arbiter.sv
// tb_ring_client_arbiter: randomized scoreboard bench with a queue-based requester/node model
module tb_ring_client_arbiter;
  localparam int W = 16, N = 3, TB = 2, TL = 8;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_grant, rsp_valid, rsp_ready = '0;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0] node_txdata, node_rxdata = '0, rsp_data;
  logic node_txvalid, node_txready = 0, node_rxvalid = 0, node_rxack;
  logic [7:0] drop_count;
  int checks = 0, failures = 0, ptr_m = 0, drops_m = 0;
  logic [W-1:0] exp_tx[$], exp_rx[$];
  logic [W-1:0] txq[N][$];
  bit mon_en = 0;

  ring_client_arbiter #(.WIDTH(W), .N(N), .TAGBITS(TB), .TAGLSB(TL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_grant(req_grant),
    .node_txdata(node_txdata), .node_txvalid(node_txvalid), .node_txready(node_txready),
    .node_rxdata(node_rxdata), .node_rxvalid(node_rxvalid), .node_rxack(node_rxack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    for (int k = 0; k < N; k++) if (k == i) oh[k] = 1'b1;
  endfunction

  // first pending requester at or after p, wrapping; -1 when nobody asks
  function automatic int rr(input int p, input logic [N-1:0] m);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] stamp(input logic [W-1:0] w, input int i);
    stamp = w;
    stamp[TL +: TB] = TB'(i);
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = txq[i].size() != 0;
      req_data[i*W +: W] = txq[i].size() != 0 ? txq[i][0] : W'($urandom);
    end
  endtask

  // one cycle: predict and check at negedge, then drive new inputs just after posedge
  task automatic step(input int p_tx, input int p_rx, input int p_rdy, input bit bad);
    int e;
    bit g, acked;
    logic [W-1:0] w;
    @(negedge clk);
    e = rr(ptr_m, req_valid);
    chk("req_grant", W'(req_grant), W'((!node_txvalid && e >= 0) ? oh(e) : '0));
    g = req_grant != '0 && e >= 0;
    if (g) begin
      exp_tx.push_back(stamp(txq[e][0], e));
      ptr_m = (e + 1) % N;
    end
    chk("drop_count", W'(drop_count), W'(drops_m > 255 ? 255 : drops_m));
    acked = node_rxack;
    if (acked) begin
      if (int'(node_rxdata[TL +: TB]) < N) exp_rx.push_back(node_rxdata);
      else drops_m++;
    end
    @(posedge clk);
    #1;
    if (g) void'(txq[e].pop_front());
    for (int i = 0; i < N; i++)
      if (int'($urandom_range(99)) < p_tx && txq[i].size() < 4) txq[i].push_back(W'($urandom));
    drive_reqs();
    node_txready = int'($urandom_range(99)) < p_rdy;
    rsp_ready = N'($urandom);
    if (acked) node_rxvalid = 0;
    if (!node_rxvalid && int'($urandom_range(99)) < p_rx) begin
      w = W'($urandom);
      if (bad) w[TL +: TB] = 2'd3;
      node_rxdata = w;
      node_rxvalid = 1;
    end
  endtask

  logic [W-1:0] prev_tx;
  bit prev_hold = 0, prev_ack = 0;
  always @(negedge clk) if (mon_en) begin
    if (prev_hold) begin
      chk("tx_hold_valid", W'(node_txvalid), 1);
      chk("tx_hold_data", node_txdata, prev_tx);
    end
    prev_hold = node_txvalid && !node_txready;
    prev_tx = node_txdata;
    if (node_txvalid && node_txready) begin
      if (exp_tx.size() == 0) fail("tx_unexpected_word");
      else chk("node_txdata", node_txdata, exp_tx.pop_front());
    end
    if (node_rxack && prev_ack) fail("rxack_back_to_back");
    prev_ack = node_rxack;
    if ((rsp_valid & rsp_ready) != '0) begin
      if (exp_rx.size() == 0) fail("rsp_unexpected_word");
      else begin
        logic [W-1:0] w;
        w = exp_rx.pop_front();
        chk("rsp_data", rsp_data, w);
        chk("rsp_valid", W'(rsp_valid), W'(oh(int'(w[TL +: TB]))));
      end
    end else if (rsp_valid != '0 && exp_rx.size() == 0) fail("rsp_valid_without_word");
  end

  initial begin
    logic [W-1:0] d0;
    int n;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", W'(req_grant), 0);
    chk("rst_txvalid", W'(node_txvalid), 0);
    chk("rst_txdata", node_txdata, 0);
    chk("rst_rsp_valid", W'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rxack", W'(node_rxack), 0);
    chk("rst_drop", W'(drop_count), 0);
    req_valid = '0;
    @(negedge clk);
    rst = 0;
    mon_en = 1;
    repeat (40) step(100, 0, 100, 0);
    repeat (700) step(40, 50, 60, 0);
    repeat (1300) step(20, 100, 70, 1);
    n = 0;
    while (n < 500 && (exp_tx.size() || exp_rx.size() || node_txvalid || rsp_valid != '0 ||
           txq[0].size() || txq[1].size() || txq[2].size() || node_rxvalid)) begin
      step(0, 0, 70, 0);
      n++;
    end
    if (n >= 500) fail("drain_timeout");
    chk("drop_saturated", W'(drop_count), 16'h00FF);
    chk("drop_model_saturated", W'(drops_m >= 255), 1);
    mon_en = 0;
    // reset while a TX word is held and the RX buffer is full
    @(posedge clk);
    #1;
    req_valid = 3'b010;
    req_data = 48'h1111_2222_3333;
    node_txready = 0;
    rsp_ready = '0;
    node_rxdata = 16'h0155;
    node_rxvalid = 1;
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #1;
    node_rxvalid = 0;
    chk("pre_rst_txvalid", W'(node_txvalid), 1);
    chk("pre_rst_txdata", node_txdata, stamp(16'h2222, 1));
    chk("pre_rst_rsp_valid", W'(rsp_valid), 16'h0002);
    chk("pre_rst_rsp_data", rsp_data, 16'h0155);
    req_valid = 3'b101;
    d0 = 16'hABCD;
    req_data = {16'h5A5A, 16'h7777, d0};
    rst = 1;
    #1;
    chk("async_rst_txvalid", W'(node_txvalid), 0);
    chk("async_rst_rsp_valid", W'(rsp_valid), 0);
    chk("async_rst_grant", W'(req_grant), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_grant", W'(req_grant), 16'h0001);
    @(posedge clk);
    #1;
    chk("post_rst_txvalid", W'(node_txvalid), 1);
    chk("post_rst_txdata", node_txdata, stamp(d0, 0));
    chk("post_rst_rsp_valid", W'(rsp_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
